// File: rtl/bus_if_types_pkg.sv
// Shared bus transaction types for the core's instruction/data buses and the
// two-master slave-port arbiter.
package bus_if_types_pkg;

  typedef enum logic {
    READ  = 1'b0,
    WRITE = 1'b1
  } ttype_e;

  // Encoding follows the load/store funct3 field
  typedef enum logic [2:0] {
    BYTE = 3'b000,
    HALF = 3'b001,
    WORD = 3'b010
  } tsize_e;

  typedef enum logic [1:0] {
    OWN_NONE = 2'b00,
    OWN_I    = 2'b01,
    OWN_D    = 2'b10
  } arb_owner_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } arb_state_e;

  typedef struct packed {
    ttype_e      ttype;
    tsize_e      tsize;
    logic [31:0] addr;
    logic [31:0] wdata;
  } bus_cmd_t;

  // Watchdog counter width: enough to hold TIMEOUT_CYCLES, never below 1 bit
  function automatic int unsigned wd_cnt_width(input int unsigned timeout);
    int unsigned w;
    w = (timeout == 32'd0) ? 32'd1 : $clog2(timeout + 32'd1);
    return (w < 32'd1) ? 32'd1 : w;
  endfunction

endpackage

// File: rtl/bus_arbiter_2m1s_rr_pick2.sv
// Two-requester winner selection: round-robin against last_served, or fixed
// priority to the D master when mode is set.
module rr_pick2
  import bus_if_types_pkg::*;
(
  input  logic       req_i,
  input  logic       req_d,
  input  arb_owner_e last_served,
  input  logic       mode,
  output arb_owner_e winner
);

  // Winner for the current request pair
  always_comb begin
    winner = OWN_NONE;
    case ({req_i, req_d})
      2'b10: winner = OWN_I;
      2'b01: winner = OWN_D;
      2'b11: begin
        if (mode) begin
          winner = OWN_D;
        end else if (last_served == OWN_I) begin
          winner = OWN_D;
        end else begin
          winner = OWN_I;
        end
      end
      default: winner = OWN_NONE;
    endcase
  end

endmodule

// File: rtl/bus_arbiter_2m1s.sv
// Shares one slave bus port between the instruction and data masters with
// transaction-level arbitration, command latching and a completion watchdog.
module bus_arbiter_2m1s
  import bus_if_types_pkg::*;
#(
  parameter int ARB_MODE       = 0,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_breq,
  input  logic        i_bstart,
  input  ttype_e      i_ttype,
  input  tsize_e      i_tsize,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  output logic        i_bdone,
  output logic        i_berr,
  output logic [31:0] i_rdata,
  input  logic        d_breq,
  input  logic        d_bstart,
  input  ttype_e      d_ttype,
  input  tsize_e      d_tsize,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_bdone,
  output logic        d_berr,
  output logic [31:0] d_rdata,
  output logic        s_breq,
  output logic        s_bstart,
  output ttype_e      s_ttype,
  output tsize_e      s_tsize,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  input  logic        s_bdone,
  input  logic [31:0] s_rdata,
  output arb_owner_e  owner
);

  localparam int unsigned      CNT_W      = wd_cnt_width(TIMEOUT_CYCLES);
  localparam logic             WD_EN      = (TIMEOUT_CYCLES != 0) ? 1'b1 : 1'b0;
  localparam logic             MODE_FIXED = (ARB_MODE != 0) ? 1'b1 : 1'b0;
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);

  arb_state_e       state_r, state_nxt_s;
  arb_owner_e       owner_r, owner_nxt_s;
  arb_owner_e       last_served_r, last_served_nxt_s;
  arb_owner_e       winner_s;
  bus_cmd_t         cmd_r, cmd_nxt_s;
  bus_cmd_t         i_cmd_s, d_cmd_s;
  logic [CNT_W-1:0] cnt_r, cnt_nxt_s;
  logic             req_i_s, req_d_s;
  logic             done_s, timeout_s;

  assign req_i_s = i_breq & i_bstart;
  assign req_d_s = d_breq & d_bstart;
  assign i_cmd_s = '{ttype: i_ttype, tsize: i_tsize, addr: i_addr, wdata: i_wdata};
  assign d_cmd_s = '{ttype: d_ttype, tsize: d_tsize, addr: d_addr, wdata: d_wdata};

  rr_pick2 u_pick (
    .req_i       (req_i_s),
    .req_d       (req_d_s),
    .last_served (last_served_r),
    .mode        (MODE_FIXED),
    .winner      (winner_s)
  );

  // Next-state, command latch and watchdog decisions
  always_comb begin
    state_nxt_s       = state_r;
    owner_nxt_s       = owner_r;
    last_served_nxt_s = last_served_r;
    cmd_nxt_s         = cmd_r;
    cnt_nxt_s         = cnt_r;
    done_s            = 1'b0;
    timeout_s         = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (winner_s != OWN_NONE) begin
          state_nxt_s = ST_BUSY;
          owner_nxt_s = winner_s;
          cnt_nxt_s   = '0;
          cmd_nxt_s   = (winner_s == OWN_D) ? d_cmd_s : i_cmd_s;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_BUSY: begin
        // Slave completion takes precedence over a coincident watchdog expiry
        if (s_bdone) begin
          done_s            = 1'b1;
          state_nxt_s       = ST_IDLE;
          owner_nxt_s       = OWN_NONE;
          last_served_nxt_s = owner_r;
        end else if (WD_EN && (cnt_r == CNT_LAST)) begin
          timeout_s   = 1'b1;
          state_nxt_s = ST_IDLE;
          owner_nxt_s = OWN_NONE;
        end else begin
          cnt_nxt_s = cnt_r + CNT_W'(1);
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        owner_nxt_s = OWN_NONE;
      end
    endcase
  end

  // State, owner, round-robin history, latched command and watchdog count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= ST_IDLE;
      owner_r       <= OWN_NONE;
      last_served_r <= OWN_D;
      cmd_r         <= '0;
      cnt_r         <= '0;
    end else begin
      state_r       <= state_nxt_s;
      owner_r       <= owner_nxt_s;
      last_served_r <= last_served_nxt_s;
      cmd_r         <= cmd_nxt_s;
      cnt_r         <= cnt_nxt_s;
    end
  end

  assign s_breq   = (state_r == ST_BUSY);
  assign s_bstart = (state_r == ST_BUSY);
  assign s_ttype  = cmd_r.ttype;
  assign s_tsize  = cmd_r.tsize;
  assign s_addr   = cmd_r.addr;
  assign s_wdata  = cmd_r.wdata;
  assign owner    = owner_r;

  assign i_bdone = (done_s | timeout_s) & (owner_r == OWN_I);
  assign i_berr  = timeout_s & (owner_r == OWN_I);
  assign i_rdata = (timeout_s && (owner_r == OWN_I)) ? 32'h0000_0000 : s_rdata;
  assign d_bdone = (done_s | timeout_s) & (owner_r == OWN_D);
  assign d_berr  = timeout_s & (owner_r == OWN_D);
  assign d_rdata = (timeout_s && (owner_r == OWN_D)) ? 32'h0000_0000 : s_rdata;

endmodule

// File: tb/tb_bus_arbiter_2m1s.sv
// Randomized bench: two arbiter instances (round-robin with a 4-cycle watchdog,
// fixed priority without watchdog) share stimulus and are checked each cycle.
module tb_bus_arbiter_2m1s;
  import bus_if_types_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_breq, i_bstart, d_breq, d_bstart, s_bdone;
  ttype_e      i_ttype, d_ttype;
  tsize_e      i_tsize, d_tsize;
  logic [31:0] i_addr, i_wdata, d_addr, d_wdata, s_rdata;

  logic        ibd [2];
  logic        ibe [2];
  logic [31:0] ird [2];
  logic        dbd [2];
  logic        dbe [2];
  logic [31:0] drd [2];
  logic        sbr [2];
  logic        sbs [2];
  ttype_e      stt [2];
  tsize_e      sts [2];
  logic [31:0] sad [2];
  logic [31:0] swd [2];
  arb_owner_e  own [2];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  bus_arbiter_2m1s #(.ARB_MODE(0), .TIMEOUT_CYCLES(4)) u_dut0 (
    .clk(clk), .rst_n(rst_n),
    .i_breq(i_breq), .i_bstart(i_bstart), .i_ttype(i_ttype), .i_tsize(i_tsize),
    .i_addr(i_addr), .i_wdata(i_wdata), .i_bdone(ibd[0]), .i_berr(ibe[0]), .i_rdata(ird[0]),
    .d_breq(d_breq), .d_bstart(d_bstart), .d_ttype(d_ttype), .d_tsize(d_tsize),
    .d_addr(d_addr), .d_wdata(d_wdata), .d_bdone(dbd[0]), .d_berr(dbe[0]), .d_rdata(drd[0]),
    .s_breq(sbr[0]), .s_bstart(sbs[0]), .s_ttype(stt[0]), .s_tsize(sts[0]),
    .s_addr(sad[0]), .s_wdata(swd[0]), .s_bdone(s_bdone), .s_rdata(s_rdata), .owner(own[0])
  );

  bus_arbiter_2m1s #(.ARB_MODE(1), .TIMEOUT_CYCLES(0)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .i_breq(i_breq), .i_bstart(i_bstart), .i_ttype(i_ttype), .i_tsize(i_tsize),
    .i_addr(i_addr), .i_wdata(i_wdata), .i_bdone(ibd[1]), .i_berr(ibe[1]), .i_rdata(ird[1]),
    .d_breq(d_breq), .d_bstart(d_bstart), .d_ttype(d_ttype), .d_tsize(d_tsize),
    .d_addr(d_addr), .d_wdata(d_wdata), .d_bdone(dbd[1]), .d_berr(dbe[1]), .d_rdata(drd[1]),
    .s_breq(sbr[1]), .s_bstart(sbs[1]), .s_ttype(stt[1]), .s_tsize(sts[1]),
    .s_addr(sad[1]), .s_wdata(swd[1]), .s_bdone(s_bdone), .s_rdata(s_rdata), .owner(own[1])
  );

  // Transaction-level reference: who holds the bus, for how long, with what command
  logic        m_busy  [2];
  arb_owner_e  m_owner [2];
  arb_owner_e  m_last  [2];
  int          m_cnt   [2];
  logic [31:0] m_addr  [2];
  logic [31:0] m_wdata [2];
  ttype_e      m_tt    [2];
  tsize_e      m_ts    [2];

  function automatic int mode_of(input int k);
    return (k == 0) ? 0 : 1;
  endfunction

  function automatic int timeout_of(input int k);
    return (k == 0) ? 4 : 0;
  endfunction

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_busy[k]  = 1'b0;
      m_owner[k] = OWN_NONE;
      m_last[k]  = OWN_D;
      m_cnt[k]   = 0;
      m_addr[k]  = 32'h0;
      m_wdata[k] = 32'h0;
      m_tt[k]    = READ;
      m_ts[k]    = BYTE;
    end
  endtask

  task automatic check_outputs(input int k);
    arb_owner_e ow;
    logic       tout, fin;
    string      p;
    p    = $sformatf("u%0d.", k);
    ow   = m_busy[k] ? m_owner[k] : OWN_NONE;
    tout = m_busy[k] && !s_bdone && (timeout_of(k) != 0) && (m_cnt[k] + 1 == timeout_of(k));
    fin  = (m_busy[k] && s_bdone) || tout;
    check_val({p, "owner"},    32'(own[k]), 32'(ow));
    check_val({p, "s_breq"},   32'(sbr[k]), 32'(m_busy[k]));
    check_val({p, "s_bstart"}, 32'(sbs[k]), 32'(m_busy[k]));
    check_val({p, "s_addr"},   sad[k], m_addr[k]);
    check_val({p, "s_wdata"},  swd[k], m_wdata[k]);
    check_val({p, "s_ttype"},  32'(stt[k]), 32'(m_tt[k]));
    check_val({p, "s_tsize"},  32'(sts[k]), 32'(m_ts[k]));
    check_val({p, "i_bdone"},  32'(ibd[k]), 32'(fin && ow == OWN_I));
    check_val({p, "i_berr"},   32'(ibe[k]), 32'(tout && ow == OWN_I));
    check_val({p, "i_rdata"},  ird[k], (tout && ow == OWN_I) ? 32'h0 : s_rdata);
    check_val({p, "d_bdone"},  32'(dbd[k]), 32'(fin && ow == OWN_D));
    check_val({p, "d_berr"},   32'(dbe[k]), 32'(tout && ow == OWN_D));
    check_val({p, "d_rdata"},  drd[k], (tout && ow == OWN_D) ? 32'h0 : s_rdata);
  endtask

  task automatic model_step(input int k);
    logic       ri, rd;
    arb_owner_e w;
    ri = i_breq && i_bstart;
    rd = d_breq && d_bstart;
    w  = OWN_NONE;
    if (m_busy[k]) begin
      if (s_bdone) begin
        m_busy[k]  = 1'b0;
        m_last[k]  = m_owner[k];
        m_owner[k] = OWN_NONE;
      end else if (timeout_of(k) != 0 && m_cnt[k] + 1 == timeout_of(k)) begin
        m_busy[k]  = 1'b0;
        m_owner[k] = OWN_NONE;
      end else begin
        m_cnt[k] = m_cnt[k] + 1;
      end
    end else begin
      if (ri && rd) w = (mode_of(k) == 1 || m_last[k] == OWN_I) ? OWN_D : OWN_I;
      else if (ri)  w = OWN_I;
      else if (rd)  w = OWN_D;
      if (w != OWN_NONE) begin
        m_busy[k]  = 1'b1;
        m_owner[k] = w;
        m_cnt[k]   = 0;
        m_addr[k]  = (w == OWN_D) ? d_addr  : i_addr;
        m_wdata[k] = (w == OWN_D) ? d_wdata : i_wdata;
        m_tt[k]    = (w == OWN_D) ? d_ttype : i_ttype;
        m_ts[k]    = (w == OWN_D) ? d_tsize : i_tsize;
      end
    end
  endtask

  task automatic drive_random(input int cyc);
    int   p, pb;
    logic ireq, dreq;
    if (cyc < 300)      begin p = 50;  pb = 30; end
    else if (cyc < 500) begin p = 100; pb = 35; end
    else if (cyc < 700) begin p = 70;  pb = 4;  end
    else                begin p = 60;  pb = 25; end
    ireq     = (int'($urandom_range(99)) < p);
    dreq     = (int'($urandom_range(99)) < p);
    i_breq   = ireq || ($urandom_range(7) == 0);
    i_bstart = ireq || (!i_breq && $urandom_range(7) == 0);
    d_breq   = dreq || ($urandom_range(7) == 0);
    d_bstart = dreq || (!d_breq && $urandom_range(7) == 0);
    i_ttype  = ttype_e'(1'($urandom_range(1)));
    d_ttype  = ttype_e'(1'($urandom_range(1)));
    i_tsize  = tsize_e'(3'($urandom_range(2)));
    d_tsize  = tsize_e'(3'($urandom_range(2)));
    i_addr   = $urandom;
    i_wdata  = $urandom;
    d_addr   = $urandom;
    d_wdata  = $urandom;
    s_bdone  = (int'($urandom_range(99)) < pb);
    s_rdata  = $urandom;
  endtask

  initial begin
    rst_n    = 1'b0;
    i_breq   = 1'b0; i_bstart = 1'b0; i_ttype = READ; i_tsize = BYTE;
    i_addr   = 32'h0; i_wdata = 32'h0;
    d_breq   = 1'b0; d_bstart = 1'b0; d_ttype = READ; d_tsize = BYTE;
    d_addr   = 32'h0; d_wdata = 32'h0;
    s_bdone  = 1'b0; s_rdata = 32'h0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    for (int k = 0; k < 2; k++) check_outputs(k);

    for (int cyc = 0; cyc < 1000; cyc++) begin
      @(negedge clk);
      rst_n = 1'b1;
      // Occasionally yank reset while the round-robin instance holds the bus
      if ((cyc % 97) == 50 && m_busy[0]) begin
        rst_n = 1'b0;
        #1;
        model_reset();
        for (int k = 0; k < 2; k++) check_outputs(k);
        continue;
      end
      drive_random(cyc);
      #1;
      for (int k = 0; k < 2; k++) begin
        check_outputs(k);
        model_step(k);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
